// File: rtl/weight_bram_pkg.sv
// Shared types and constants for the weight BRAM arbiter.
package weight_bram_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WEN_ALL    = 4'b1111;
  localparam logic [3:0] WEN_NONE   = 4'b0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: read vs. host write.
// A tie goes to the read unless the read won the previous grant.
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_rd,
  input  logic i_req_wr,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);

  logic r_last_gnt_rd;
  logic w_gnt_rd;
  logic w_gnt_wr;

  // Grant decision, only inside the arbitration window
  always_comb begin
    w_gnt_rd = i_en & i_req_rd & (~i_req_wr | ~r_last_gnt_rd);
    w_gnt_wr = i_en & i_req_wr & ~w_gnt_rd;
  end

  // Remember who won the most recent grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_gnt_rd <= 1'b0;
    end else if (w_gnt_rd | w_gnt_wr) begin
      r_last_gnt_rd <= w_gnt_rd;
    end
  end

  assign o_gnt_rd = w_gnt_rd;
  assign o_gnt_wr = w_gnt_wr;

endmodule

// File: rtl/weight_bram_arbiter.sv
// Shares a single-port weight BRAM between a host word writer and
// convolution-engine read bursts.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | arbitrate host write vs. burst request
// ST_WRITE | single write cycle on the BRAM port
// ST_READ  | one read issue per cycle, down-counting remaining words
// ST_DRAIN | last read beat returning from the BRAM
module weight_bram_arbiter
  import weight_bram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1001,
  parameter int LEN_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_h_valid,
  output logic              o_h_ready,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  input  logic              i_r_start,
  input  logic [ADDR_W-1:0] i_r_base,
  input  logic [LEN_W-1:0]  i_r_len,
  output logic              o_r_busy,
  output logic [DATA_W-1:0] o_r_data,
  output logic              o_r_dvalid,
  output logic              o_r_last,
  output logic              o_err,
  output logic              o_m_en,
  output logic [3:0]        o_m_wen,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_din,
  input  logic [DATA_W-1:0] i_m_dout
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] LP_STEP  = ADDR_W'(WORD_BYTES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_remain;
  logic [LEN_W-1:0]    w_remain_nxt;
  logic                r_m_en;
  logic                w_m_en_nxt;
  logic [3:0]          r_m_wen;
  logic [3:0]          w_m_wen_nxt;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [ADDR_W-1:0]   w_m_addr_nxt;
  logic [DATA_W-1:0]   r_m_din;
  logic [DATA_W-1:0]   w_m_din_nxt;
  logic                r_err;
  logic                w_err_set;
  logic                r_dvalid;
  logic                r_last;

  logic                w_idle;
  logic                w_rd_req;
  logic                w_gnt_rd;
  logic                w_gnt_wr;
  logic [ADDR_W-1:0]   w_h_word;
  logic                w_h_in_range;
  logic [ADDR_W-1:0]   w_r_base_w;
  logic [ADDR_W:0]     w_r_end;
  logic                w_r_ok;
  logic                w_last_issue;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_rd_req = i_r_start & (i_r_len != '0);

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_idle),
    .i_req_rd (w_rd_req),
    .i_req_wr (i_h_valid),
    .o_gnt_rd (w_gnt_rd),
    .o_gnt_wr (w_gnt_wr)
  );

  // Range checks; the burst end is computed one bit wider so it cannot wrap
  always_comb begin
    w_h_word     = i_h_addr >> 2;
    w_h_in_range = ({1'b0, w_h_word} < LP_DEPTH);
    w_r_base_w   = i_r_base >> 2;
    w_r_end      = {1'b0, w_r_base_w} + {{(ADDR_W+1-LEN_W){1'b0}}, i_r_len};
    w_r_ok       = (w_r_end <= LP_DEPTH);
  end

  assign w_last_issue = (r_state == ST_READ) && (r_remain == '0);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a rejected burst leaves the FSM in IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_wr) begin
          w_state_nxt = ST_WRITE;
        end else if (w_gnt_rd && w_r_ok) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      ST_READ:  w_state_nxt = w_last_issue ? ST_DRAIN : ST_READ;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered BRAM port, counter and error flag
  always_comb begin
    w_m_en_nxt   = 1'b0;
    w_m_wen_nxt  = WEN_NONE;
    w_m_addr_nxt = r_m_addr;
    w_m_din_nxt  = r_m_din;
    w_remain_nxt = r_remain;
    w_err_set    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_wr) begin
          w_m_addr_nxt = w_h_word << 2;
          w_m_din_nxt  = i_h_wdata;
          if (w_h_in_range) begin
            w_m_en_nxt  = 1'b1;
            w_m_wen_nxt = WEN_ALL;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (w_gnt_rd) begin
          if (w_r_ok) begin
            w_m_en_nxt   = 1'b1;
            w_m_addr_nxt = w_r_base_w << 2;
            w_remain_nxt = i_r_len - LEN_W'(1);
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!w_last_issue) begin
          w_m_en_nxt   = 1'b1;
          w_m_addr_nxt = r_m_addr + LP_STEP;
          w_remain_nxt = r_remain - LEN_W'(1);
        end
      end
      default: begin
        w_m_en_nxt = 1'b0;
      end
    endcase
  end

  // Registered BRAM port, burst counter, sticky error and read-valid pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m_en   <= 1'b0;
      r_m_wen  <= WEN_NONE;
      r_m_addr <= '0;
      r_m_din  <= '0;
      r_remain <= '0;
      r_err    <= 1'b0;
      r_dvalid <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_m_en   <= w_m_en_nxt;
      r_m_wen  <= w_m_wen_nxt;
      r_m_addr <= w_m_addr_nxt;
      r_m_din  <= w_m_din_nxt;
      r_remain <= w_remain_nxt;
      r_err    <= r_err | w_err_set;
      r_dvalid <= (r_state == ST_READ);
      r_last   <= w_last_issue;
    end
  end

  assign o_h_ready  = w_gnt_wr;
  assign o_r_busy   = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign o_r_data   = i_m_dout;
  assign o_r_dvalid = r_dvalid;
  assign o_r_last   = r_last;
  assign o_err      = r_err;
  assign o_m_en     = r_m_en;
  assign o_m_wen    = r_m_wen;
  assign o_m_addr   = r_m_addr;
  assign o_m_din    = r_m_din;

endmodule

// File: tb/tb_weight_bram_arbiter.sv
// Bench for weight_bram_arbiter: transaction-level reference model with a
// per-cycle expectation ring, a behavioural BRAM, directed cases and random traffic.
module tb_weight_bram_arbiter;

  localparam int DEPTH = 1001;
  localparam int RING  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_valid = 1'b0;
  logic        h_ready;
  logic [31:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        r_start = 1'b0;
  logic [31:0] r_base = '0;
  logic [9:0]  r_len = '0;
  logic        r_busy;
  logic [31:0] r_data;
  logic        r_dvalid;
  logic        r_last;
  logic        err;
  logic        m_en;
  logic [3:0]  m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_bram_arbiter #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LEN_W(10)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_h_valid(h_valid), .o_h_ready(h_ready), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .i_r_start(r_start), .i_r_base(r_base), .i_r_len(r_len),
    .o_r_busy(r_busy), .o_r_data(r_data), .o_r_dvalid(r_dvalid), .o_r_last(r_last),
    .o_err(err), .o_m_en(m_en), .o_m_wen(m_wen), .o_m_addr(m_addr), .o_m_din(m_din),
    .i_m_dout(m_dout)
  );

  // behavioural single-port BRAM with registered read data
  logic [31:0] bram [0:DEPTH-1];
  always @(posedge clk) begin
    if (m_en && ((m_addr >> 2) < DEPTH)) begin
      if (m_wen == 4'hF) bram[m_addr >> 2] <= m_din;
      else               m_dout <= bram[m_addr >> 2];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:DEPTH-1];
  longint      free_at = 0;
  bit          last_rd = 0;
  bit          merr = 0;
  longint      err_cyc = 0;
  bit          g_rd_f = 0, g_wr_f = 0, idle_f = 0;

  bit          e_en   [RING];
  logic [3:0]  e_wen  [RING];
  logic [31:0] e_addr [RING];
  logic [31:0] e_din  [RING];
  bit          e_dv   [RING];
  bit          e_last [RING];
  bit          e_busy [RING];
  logic [31:0] e_rd   [RING];

  function automatic int ri(input longint c);
    return int'(c % RING);
  endfunction

  task automatic clear_slot(input int s);
    e_en[s] = 0; e_wen[s] = 4'h0; e_addr[s] = '0; e_din[s] = '0;
    e_dv[s] = 0; e_last[s] = 0; e_busy[s] = 0; e_rd[s] = '0;
  endtask

  task automatic set_err(input longint c);
    if (!merr) begin
      merr = 1;
      err_cyc = c + 1;
    end
  endtask

  // compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin : cmp
    int     s;
    bit     idle, rq, wq, grd, gwr;
    longint word, base, len;
    s = ri(cyc);
    if (rst) begin
      chk("rst_m_en", m_en, 0);
      chk("rst_m_wen", m_wen, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_din", m_din, 0);
      chk("rst_r_dvalid", r_dvalid, 0);
      chk("rst_r_last", r_last, 0);
      chk("rst_r_busy", r_busy, 0);
      chk("rst_err", err, 0);
      for (int i = 0; i < RING; i++) clear_slot(i);
      free_at = cyc + 1;
      last_rd = 0;
      merr = 0;
      g_rd_f = 0; g_wr_f = 0; idle_f = 0;
    end else begin
      chk("m_en", m_en, e_en[s]);
      if (e_en[s]) begin
        chk("m_wen", m_wen, e_wen[s]);
        chk("m_addr", m_addr, e_addr[s]);
        if (e_wen[s] == 4'hF) chk("m_din", m_din, e_din[s]);
      end else begin
        chk("m_wen_off", m_wen, 0);
      end
      chk("r_dvalid", r_dvalid, e_dv[s]);
      chk("r_last", r_last, e_last[s]);
      chk("r_busy", r_busy, e_busy[s]);
      if (e_dv[s]) chk("r_data", r_data, e_rd[s]);
      chk("err", err, merr && (cyc >= err_cyc));
      clear_slot(s);

      idle = (cyc >= free_at);
      rq   = r_start && (r_len != 0);
      wq   = h_valid;
      grd  = idle && rq && (!wq || !last_rd);
      gwr  = idle && wq && !grd;
      chk("h_ready", h_ready, gwr);
      if (grd || gwr) last_rd = grd;

      if (gwr) begin
        word = longint'(h_addr >> 2);
        if (word < DEPTH) begin
          e_en[ri(cyc+1)]   = 1;
          e_wen[ri(cyc+1)]  = 4'hF;
          e_addr[ri(cyc+1)] = 32'(word * 4);
          e_din[ri(cyc+1)]  = h_wdata;
          mem[word] = h_wdata;
        end else begin
          set_err(cyc);
        end
        free_at = cyc + 2;
      end
      if (grd) begin
        base = longint'(r_base >> 2);
        len  = longint'(r_len);
        if (base + len > DEPTH) begin
          set_err(cyc);
        end else begin
          for (int i = 0; i < len; i++) begin
            e_en[ri(cyc+1+i)]   = 1;
            e_wen[ri(cyc+1+i)]  = 4'h0;
            e_addr[ri(cyc+1+i)] = 32'((base + i) * 4);
            e_dv[ri(cyc+2+i)]   = 1;
            e_rd[ri(cyc+2+i)]   = mem[base + i];
          end
          for (int i = 1; i <= len + 1; i++) e_busy[ri(cyc+i)] = 1;
          e_last[ri(cyc+len+1)] = 1;
          free_at = cyc + len + 2;
        end
      end
      g_rd_f = grd;
      g_wr_f = gwr;
      idle_f = idle && !grd && !gwr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_gnt(input bit rd);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(rd ? g_rd_f : g_wr_f) && n < 60);
    n_chk++;
    if (!(rd ? g_rd_f : g_wr_f)) begin
      n_err++;
      $display("FAIL grant_timeout: rd=%0d no grant after %0d cycles, expected a grant", rd, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!idle_f && n < 100);
    n_chk++;
    if (!idle_f) begin
      n_err++;
      $display("FAIL idle_timeout: model not idle after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hp, rp;
    int w;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = 32'hA500_0000 ^ (i * 32'h9E37_79B1);
      mem[i]  = 32'hA500_0000 ^ (i * 32'h9E37_79B1);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // reset pulse mid-cycle with a write pending
    wait_idle();
    #1 h_valid = 1'b1; h_addr = 32'h10; h_wdata = 32'hDEAD_BEEF;
    #1 rst = 1'b1;
    #1;
    chk("d_rst_h_ready", h_ready, 1);
    chk("d_rst_m_en", m_en, 0);
    chk("d_rst_err", err, 0);
    chk("d_rst_busy", r_busy, 0);
    @(posedge clk); #2 rst = 1'b0;

    // write 0xDEADBEEF to 0x10
    wait_gnt(0);
    #1 h_valid = 1'b0;
    @(negedge clk);
    chk("d_wr_m_en", m_en, 1);
    chk("d_wr_m_wen", m_wen, 4'hF);
    chk("d_wr_m_addr", m_addr, 32'h10);
    chk("d_wr_m_din", m_din, 32'hDEAD_BEEF);

    // single-word read of the same address
    wait_idle();
    #1 r_start = 1'b1; r_base = 32'h10; r_len = 10'd1;
    wait_gnt(1);
    #1 r_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("d_rd1_dvalid", r_dvalid, 1);
    chk("d_rd1_last", r_last, 1);
    chk("d_rd1_data", r_data, 32'hDEAD_BEEF);

    // four-word burst from 0
    wait_idle();
    #1 r_start = 1'b1; r_base = 32'h0; r_len = 10'd4;
    wait_gnt(1);
    #1 r_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d_b4_addr", m_addr, 32'(i * 4));
    end
    @(negedge clk);
    chk("d_b4_last", r_last, 1);
    chk("d_b4_dvalid", r_dvalid, 1);
    @(negedge clk);
    chk("d_b4_busy_end", r_busy, 0);

    // contention right after reset: read first, then the tie goes to the write
    wait_idle();
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    h_valid = 1'b1; h_addr = 32'h20; h_wdata = 32'h1234_5678;
    r_start = 1'b1; r_base = 32'h40; r_len = 10'd2;
    @(negedge clk);
    chk("d_tie1_h_ready", h_ready, 0);
    wait_gnt(1);
    repeat (4) @(negedge clk);
    chk("d_tie2_h_ready", h_ready, 1);
    @(posedge clk); #1 h_valid = 1'b0;
    wait_gnt(1);
    #1 r_start = 1'b0;

    // range errors: burst past the end, then an out-of-range write
    wait_idle();
    #1 r_start = 1'b1; r_base = 32'hF9C; r_len = 10'd3;
    wait_gnt(1);
    #1 r_start = 1'b0;
    @(negedge clk);
    chk("d_rng_err", err, 1);
    chk("d_rng_m_en", m_en, 0);
    wait_idle();
    #1 h_valid = 1'b1; h_addr = 32'hFA4; h_wdata = 32'h5555_AAAA;
    wait_gnt(0);
    #1 h_valid = 1'b0;
    @(negedge clk);
    chk("d_rngw_m_en", m_en, 0);
    chk("d_rngw_err", err, 1);

    // reset in the middle of an 8-word burst, then a 2-word burst
    wait_idle();
    #1 r_start = 1'b1; r_base = 32'h100; r_len = 10'd8;
    wait_gnt(1);
    #1 r_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("d_mid_dvalid", r_dvalid, 0);
    chk("d_mid_busy", r_busy, 0);
    chk("d_mid_m_en", m_en, 0);
    @(posedge clk); #2 rst = 1'b0;
    wait_idle();
    #1 r_start = 1'b1; r_base = 32'h200; r_len = 10'd2;
    wait_gnt(1);
    #1 r_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("d_post_last", r_last, 1);
    @(negedge clk);
    chk("d_post_busy", r_busy, 0);

    // random traffic; requesters hold until granted
    hp = 0; rp = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (g_wr_f) hp = 0;
      if (g_rd_f) rp = 0;
      if (k % 300 == 299 && idle_f) begin
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        #1;
        if (rp && r_len == 0) rp = 0;
        if (!hp && $urandom_range(0, 99) < 30) begin
          hp = 1;
          w  = ($urandom_range(0, 99) < 8) ? $urandom_range(1001, 1100) : $urandom_range(0, 1000);
          h_addr  = 32'(w * 4 + $urandom_range(0, 3));
          h_wdata = $urandom;
        end
        if (!rp && $urandom_range(0, 99) < 25) begin
          rp = 1;
          w  = ($urandom_range(0, 99) < 10) ? $urandom_range(985, 1000) : $urandom_range(0, 1000);
          r_base = 32'(w * 4 + $urandom_range(0, 3));
          r_len  = 10'($urandom_range(0, 12));
        end
        h_valid = hp;
        r_start = rp;
      end
    end
    h_valid = 1'b0;
    r_start = 1'b0;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
